pwm_gen: RTL and testbench

- Downstream consumer of the timer counter: compares the live `count_val` against programmed compare values and drives the PWM output pin.
- Compare and mode settings are double-buffered in shadow registers that reload only at a period boundary, so a register write never causes a glitch mid-period.
- Sits between the counter/register file and the pad.

---
 rtl/pwm_gen.sv | 119 +++++++++++
 tb/tb_pwm_gen.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_gen.sv
// pwm_gen: compares the live counter value against double-buffered compare settings
// and drives a complementary PWM pin pair. Define PWM_DEADTIME_EN to add dead-time insertion.
module pwm_gen #(
    parameter int CW  = 16,
    parameter int DTW = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [CW-1:0]  count_val,
    input  logic [CW-1:0]  period,
    input  logic           count_reset,
    input  logic           pwm_en,
    input  logic [1:0]     functions,
    input  logic [CW-1:0]  compare1,
    input  logic [CW-1:0]  compare2,
    input  logic [DTW-1:0] deadtime,
    output logic           pwm_out,
    output logic           pwm_out_n
);

    logic [CW-1:0] prev_cnt;
    logic [CW-1:0] cmp1_s;
    logic [CW-1:0] cmp2_s;
    logic [1:0]    fn_s;
    logic [CW-1:0] eff_cnt;
    logic          wrap;
    logic          reload;
    logic          raw;

    // Edge detect on the counter returning to zero; the count may hold for several clks.
    assign wrap    = (count_val == '0) && (prev_cnt != '0);
    assign reload  = wrap || count_reset || !pwm_en;
    assign eff_cnt = count_reset ? '0 : count_val;

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_cnt <= '0;
            cmp1_s   <= '0;
            cmp2_s   <= '0;
            fn_s     <= '0;
        end else begin
            prev_cnt <= count_val;
            if (reload) begin
                cmp1_s <= compare1;
                cmp2_s <= compare2;
                fn_s   <= functions;
            end
        end
    end

    always_comb begin
        // NOTE: default assignment first so no path leaves raw unassigned (no latch).
        raw = 1'b0;
        if (fn_s[1]) begin
            raw = (eff_cnt >= cmp1_s) && (eff_cnt < cmp2_s);
        end else if (fn_s[0]) begin
            raw = (eff_cnt >= cmp1_s);
        end else begin
            raw = (eff_cnt < cmp1_s);
        end
    end

`ifdef PWM_DEADTIME_EN
    logic [DTW-1:0] dt_cnt;
    logic           lvl;
    logic           unused_cfg;

    assign unused_cfg = ^period;

    // lvl is the target level; dt_cnt counts the remaining gap clks after the first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dt_cnt    <= '0;
            lvl       <= 1'b0;
            pwm_out   <= 1'b0;
            pwm_out_n <= 1'b0;
        end else if (!pwm_en) begin
            dt_cnt    <= '0;
            lvl       <= 1'b0;
            pwm_out   <= 1'b0;
            pwm_out_n <= 1'b0;
        end else if (raw != lvl) begin
            lvl <= raw;
            if (deadtime != '0) begin
                dt_cnt    <= deadtime - 1'b1;
                pwm_out   <= 1'b0;
                pwm_out_n <= 1'b0;
            end else begin
                dt_cnt    <= '0;
                pwm_out   <= raw;
                pwm_out_n <= ~raw;
            end
        end else if (dt_cnt != '0) begin
            dt_cnt    <= dt_cnt - 1'b1;
            pwm_out   <= 1'b0;
            pwm_out_n <= 1'b0;
        end else begin
            pwm_out   <= lvl;
            pwm_out_n <= ~lvl;
        end
    end
`else
    logic unused_cfg;

    assign unused_cfg = ^{period, deadtime};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_out   <= 1'b0;
            pwm_out_n <= 1'b0;
        end else begin
            pwm_out   <= pwm_en && raw;
            pwm_out_n <= pwm_en && !raw;
        end
    end
`endif

endmodule

// File: tb/tb_pwm_gen.sv
// tb_pwm_gen: drives an emulated prescaled counter into pwm_gen and scoreboards the
// PWM pin pair against a cycle-level reference model (dead-time model under PWM_DEADTIME_EN).
module tb_pwm_gen;

    localparam int CW  = 16;
    localparam int DTW = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [CW-1:0]  count_val;
    logic [CW-1:0]  period;
    logic           count_reset;
    logic           pwm_en;
    logic [1:0]     functions;
    logic [CW-1:0]  compare1;
    logic [CW-1:0]  compare2;
    logic [DTW-1:0] deadtime;
    logic           pwm_out;
    logic           pwm_out_n;

    pwm_gen #(.CW(CW), .DTW(DTW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .count_val  (count_val),
        .period     (period),
        .count_reset(count_reset),
        .pwm_en     (pwm_en),
        .functions  (functions),
        .compare1   (compare1),
        .compare2   (compare2),
        .deadtime   (deadtime),
        .pwm_out    (pwm_out),
        .pwm_out_n  (pwm_out_n)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic out;
        logic outn;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: the settings that govern the current period.
    int unsigned m_c1, m_c2, m_fn, m_prev;
    int          m_lvl, m_since, m_gap;

    // Emulated counter feeding count_val.
    int unsigned c_cnt, c_pre, c_presc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_c1 = 0; m_c2 = 0; m_fn = 0; m_prev = 0;
        m_lvl = 0; m_since = 1000; m_gap = 0;
    endtask

    // Expected pins after the coming edge, from the settings in force this period.
    task automatic model_cycle();
        exp_t        e;
        int unsigned pos;
        int          r;
        pos = count_reset ? 0 : int'(count_val);
        if (m_fn >= 2)      r = (pos >= m_c1 && pos < m_c2) ? 1 : 0;
        else if (m_fn == 1) r = (pos >= m_c1) ? 1 : 0;
        else                r = (pos < m_c1) ? 1 : 0;
`ifdef PWM_DEADTIME_EN
        if (!pwm_en) begin
            m_lvl = 0; m_since = 1000; m_gap = 0;
            e.out = 1'b0; e.outn = 1'b0;
        end else begin
            if (r != m_lvl) begin
                m_lvl = r; m_since = 0; m_gap = int'(deadtime);
            end else if (m_since < 1000) begin
                m_since++;
            end
            if (m_since < m_gap) begin
                e.out = 1'b0; e.outn = 1'b0;
            end else begin
                e.out = (m_lvl == 1); e.outn = (m_lvl == 0);
            end
        end
`else
        e.out  = pwm_en && (r == 1);
        e.outn = pwm_en && (r == 0);
`endif
        if ((count_val == 0 && m_prev != 0) || count_reset || !pwm_en) begin
            m_c1 = compare1; m_c2 = compare2; m_fn = functions;
        end
        m_prev = count_val;
        sb.push_back(e);
    endtask

    task automatic next_counter();
        if (count_reset) begin
            c_cnt = 0; c_pre = 0;
        end else if (c_pre + 1 >= c_presc) begin
            c_pre = 0;
            c_cnt = (c_cnt >= period) ? 0 : c_cnt + 1;
        end else begin
            c_pre++;
        end
        count_val = CW'(c_cnt);
    endtask

    // One clk: called at a negedge with this cycle's inputs already applied.
    task automatic cycle();
        model_cycle();
        @(negedge clk);
        next_counter();
        count_reset = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic run_until(input int unsigned v);
        for (int i = 0; i < 200 && count_val != CW'(v); i++) cycle();
    endtask

    // Monitor: outputs are presented every clk; compare 1 time unit after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("pwm_out", 32'(pwm_out), 32'(e.out));
                check("pwm_out_n", 32'(pwm_out_n), 32'(e.outn));
                if (pwm_out && pwm_out_n) check("overlap", 32'(1), 32'(0));
            end
        end
    end

    initial begin
        rst_n = 1'b1; count_val = '0; period = CW'(9); count_reset = 1'b0; pwm_en = 1'b0;
        functions = 2'b00; compare1 = '0; compare2 = '0; deadtime = '0;
        c_cnt = 0; c_pre = 0; c_presc = 1;
        model_reset();
        #3 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset_out", 32'(pwm_out), 32'(0));
        check("reset_out_n", 32'(pwm_out_n), 32'(0));

        // Left aligned, compare1=3, shadows loaded while disabled.
        compare1 = CW'(3);
        rst_n = 1'b1;
        run(2);
        pwm_en = 1'b1;
        run(22);

        // Mid-period write is held until the wrap.
        run_until(5);
        compare1 = CW'(7);
        run(22);

        // Range mode, then inverted range gives constant 0.
        functions = 2'b10; compare1 = CW'(2); compare2 = CW'(6);
        run(25);
        compare1 = CW'(6); compare2 = CW'(2);
        run(25);

        // Boundaries.
        functions = 2'b00; compare1 = CW'(0);
        run(15);
        compare1 = CW'(20);
        run(15);
        functions = 2'b01; compare1 = CW'(0);
        run(15);

        // Disable while high, re-enable without waiting for wrap.
        functions = 2'b00; compare1 = CW'(3);
        run(12);
        run_until(1);
        pwm_en = 1'b0;
        run(3);
        pwm_en = 1'b1;
        run(8);

        // Counter reset strobe mid-period with a pending write.
        run_until(6);
        compare1 = CW'(5);
        count_reset = 1'b1;
        run(15);

        // Asynchronous reset mid-period clears immediately.
        run_until(4);
        rst_n = 1'b0;
        #1;
        check("async_rst_out", 32'(pwm_out), 32'(0));
        check("async_rst_out_n", 32'(pwm_out_n), 32'(0));
        model_reset();
        @(negedge clk); next_counter();
        @(negedge clk); next_counter();
        rst_n = 1'b1;
        run(25);

        // Dead-time 3 and 0 on the left-aligned settings (ignored without the macro).
        compare1 = CW'(3);
        deadtime = DTW'(3);
        run(30);
        deadtime = DTW'(0);
        run(25);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) period = CW'($urandom_range(4, 30));
            if ($urandom_range(0, 199) == 0) c_presc = $urandom_range(1, 3);
            if ($urandom_range(0, 7) == 0) compare1 = CW'($urandom_range(0, int'(period) + 3));
            if ($urandom_range(0, 7) == 0) compare2 = CW'($urandom_range(0, int'(period) + 3));
            if ($urandom_range(0, 15) == 0) functions = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 31) == 0) deadtime = DTW'($urandom_range(0, 4));
            if ($urandom_range(0, 39) == 0) count_reset = 1'b1;
            pwm_en = ($urandom_range(0, 29) != 0);
            cycle();
        end

        @(posedge clk);
        #2;
        check("sb_drain", 32'(sb.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
